// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Purpose:
//   Shares the single write port of the 16 x 32 register file between the
//   ALU writeback path (wb) and the load-return path (ld). It also keeps a
//   scoreboard of registers with an outstanding load, so that:
//     - decode sees read-after-write hazards (hazard1/hazard2),
//     - ALU writebacks to a register with a pending load are stalled (WAW),
//     - a load returning to an unreserved register raises err_stray.
//
// Configuration macro:
//   RFARB_ROUND_ROBIN_EN - when defined, contention between wb and ld is
//   resolved round-robin (ld wins the first contention after reset). When
//   undefined, ld always wins and wb_ready also requires ld_valid = 0.
//
// Ports:
//   clk, res                    clock, asynchronous active-low reset
//   wb_valid/wb_rd/wb_data      ALU writeback request, wb_ready = granted
//   ld_valid/ld_rd/ld_data      load-return request, ld_ready = granted
//   rsv_valid/rsv_rd            load-destination reservation, rsv_ready
//   chk_rs1/chk_rs2             decode sources, hazard1/hazard2 = busy
//   rf_wrtEn/rf_rd/rf_wrtData   registered register-file write port
//   busy                        scoreboard vector
//   err_stray                   sticky stray-load flag
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic [DW-1:0]    wb_data,
    output logic             wb_ready,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_rd,
    input  logic [DW-1:0]    ld_data,
    output logic             ld_ready,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_rd,
    output logic             rsv_ready,
    input  logic [AW-1:0]    chk_rs1,
    input  logic [AW-1:0]    chk_rs2,
    output logic             hazard1,
    output logic             hazard2,
    output logic             rf_wrtEn,
    output logic [AW-1:0]    rf_rd,
    output logic [DW-1:0]    rf_wrtData,
    output logic [NREGS-1:0] busy,
    output logic             err_stray
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic             wrEn_q, wrEn_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [DW-1:0]    data_q, data_d;
    logic             fromLd_q, fromLd_d;
    logic             err_q, err_d;

    logic wbElig;
    logic wbGrant;
    logic ldGrant;
    logic rsvGrant;

    // A writeback may only proceed when no load is pending for its target.
    assign wbElig = ~busy_q[wb_rd];

`ifdef RFARB_ROUND_ROBIN_EN
    // prefLd_q = 1 means ld wins the next contention; it flips only when
    // both requesters are valid and eligible in the same cycle.
    logic prefLd_q, prefLd_d;
    logic contention;

    always_comb begin
        contention = wb_valid & wbElig & ld_valid;
        ld_ready   = ~(wb_valid & wbElig) | prefLd_q;
        wb_ready   = wbElig & (~ld_valid | ~prefLd_q);
        prefLd_d   = prefLd_q;
        if (contention) begin
            prefLd_d = ~prefLd_q;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            prefLd_q <= 1'b1;
        end else begin
            prefLd_q <= prefLd_d;
        end
    end
`else
    // Fixed priority: a load return is never held off.
    always_comb begin
        ld_ready = 1'b1;
        wb_ready = wbElig & ~ld_valid;
    end
`endif

    assign ldGrant   = ld_valid & ld_ready;
    assign wbGrant   = wb_valid & wb_ready;
    assign rsv_ready = ~busy_q[rsv_rd];
    assign rsvGrant  = rsv_valid & rsv_ready;

    // Next-state for the output stage and scoreboard. The clear is applied
    // before the set; they can only collide on the same register if a
    // reservation were accepted while busy, which rsv_ready forbids.
    always_comb begin
        wrEn_d   = ldGrant | wbGrant;
        rd_d     = rd_q;
        data_d   = data_q;
        fromLd_d = fromLd_q;
        busy_d   = busy_q;
        err_d    = err_q;

        if (ldGrant) begin
            rd_d     = ld_rd;
            data_d   = ld_data;
            fromLd_d = 1'b1;
        end else if (wbGrant) begin
            rd_d     = wb_rd;
            data_d   = wb_data;
            fromLd_d = 1'b0;
        end

        if (wrEn_q && fromLd_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (rsvGrant) begin
            busy_d[rsv_rd] = 1'b1;
        end

        if (ldGrant && !busy_q[ld_rd]) begin
            err_d = 1'b1;
        end
    end

    // State registers; reset discards any write sitting in the output stage.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wrEn_q   <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            fromLd_q <= 1'b0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wrEn_q   <= wrEn_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            fromLd_q <= fromLd_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign rf_wrtEn   = wrEn_q;
    assign rf_rd      = rd_q;
    assign rf_wrtData = data_q;
    assign busy       = busy_q;
    assign err_stray  = err_q;
    assign hazard1    = busy_q[chk_rs1];
    assign hazard2    = busy_q[chk_rs2];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Self-checking bench for rf_write_arbiter: a directed cycle table, a
// contention sequence, an asynchronous reset sequence, then randomized
// traffic compared against a behavioural scoreboard model.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    logic        clk;
    logic        res;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        ld_valid;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rsv_valid;
    logic [3:0]  rsv_rd;
    logic        rsv_ready;
    logic [3:0]  chk_rs1;
    logic [3:0]  chk_rs2;
    logic        hazard1;
    logic        hazard2;
    logic        rf_wrtEn;
    logic [3:0]  rf_rd;
    logic [31:0] rf_wrtData;
    logic [15:0] busy;
    logic        err_stray;

    int totalChecks;
    int badChecks;

    rf_write_arbiter #(.NREGS(16), .AW(4), .DW(32)) dut (
        .clk        (clk),
        .res        (res),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .rsv_valid  (rsv_valid),
        .rsv_rd     (rsv_rd),
        .rsv_ready  (rsv_ready),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .rf_wrtEn   (rf_wrtEn),
        .rf_rd      (rf_rd),
        .rf_wrtData (rf_wrtData),
        .busy       (busy),
        .err_stray  (err_stray)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wbV;
        logic [3:0]  wbRd;
        logic [31:0] wbD;
        logic        ldV;
        logic [3:0]  ldRd;
        logic [31:0] ldD;
        logic        rsvV;
        logic [3:0]  rsvRd;
        logic [3:0]  c1;
        logic [3:0]  c2;
        logic        eWbR;
        logic        eLdR;
        logic        eRsvR;
        logic        eH1;
        logic        eH2;
        logic        eEn;
        logic [3:0]  eRd;
        logic [31:0] eData;
        logic [15:0] eBusy;
        logic        eErr;
    } vec_t;

    vec_t vecs[17];

    // Behavioural reference state for the random phase.
    logic [15:0] mBusy;
    logic        mEn;
    logic [3:0]  mRd;
    logic [31:0] mData;
    logic        mFromLd;
    logic        mErr;
    logic        mPrefLd;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(input logic wbV, input logic [3:0] wbRd, input logic [31:0] wbD,
                                 input logic ldV, input logic [3:0] ldRd, input logic [31:0] ldD,
                                 input logic rsvV, input logic [3:0] rsvRd,
                                 input logic [3:0] c1, input logic [3:0] c2);
        wb_valid  = wbV;
        wb_rd     = wbRd;
        wb_data   = wbD;
        ld_valid  = ldV;
        ld_rd     = ldRd;
        ld_data   = ldD;
        rsv_valid = rsvV;
        rsv_rd    = rsvRd;
        chk_rs1   = c1;
        chk_rs2   = c2;
    endtask

    task automatic setIn(input int i, input logic wbV, input logic [3:0] wbRd, input logic [31:0] wbD,
                         input logic ldV, input logic [3:0] ldRd, input logic [31:0] ldD,
                         input logic rsvV, input logic [3:0] rsvRd,
                         input logic [3:0] c1, input logic [3:0] c2);
        vecs[i].wbV = wbV;  vecs[i].wbRd = wbRd;  vecs[i].wbD = wbD;
        vecs[i].ldV = ldV;  vecs[i].ldRd = ldRd;  vecs[i].ldD = ldD;
        vecs[i].rsvV = rsvV; vecs[i].rsvRd = rsvRd;
        vecs[i].c1 = c1;    vecs[i].c2 = c2;
    endtask

    task automatic setExp(input int i, input logic wbR, input logic ldR, input logic rsvR,
                          input logic h1, input logic h2, input logic en, input logic [3:0] rd,
                          input logic [31:0] data, input logic [15:0] bsy, input logic err);
        vecs[i].eWbR = wbR;  vecs[i].eLdR = ldR;  vecs[i].eRsvR = rsvR;
        vecs[i].eH1 = h1;    vecs[i].eH2 = h2;    vecs[i].eEn = en;
        vecs[i].eRd = rd;    vecs[i].eData = data; vecs[i].eBusy = bsy;
        vecs[i].eErr = err;
    endtask

    task automatic checkAll(input string tag, input logic eWbR, input logic eLdR, input logic eRsvR,
                            input logic eH1, input logic eH2, input logic eEn, input logic [3:0] eRd,
                            input logic [31:0] eData, input logic [15:0] eBusy, input logic eErr);
        checkOutput({tag, " wb_ready"}, 32'(wb_ready), 32'(eWbR));
        checkOutput({tag, " ld_ready"}, 32'(ld_ready), 32'(eLdR));
        checkOutput({tag, " rsv_ready"}, 32'(rsv_ready), 32'(eRsvR));
        checkOutput({tag, " hazard1"}, 32'(hazard1), 32'(eH1));
        checkOutput({tag, " hazard2"}, 32'(hazard2), 32'(eH2));
        checkOutput({tag, " rf_wrtEn"}, 32'(rf_wrtEn), 32'(eEn));
        checkOutput({tag, " rf_rd"}, 32'(rf_rd), 32'(eRd));
        checkOutput({tag, " rf_wrtData"}, rf_wrtData, eData);
        checkOutput({tag, " busy"}, 32'(busy), 32'(eBusy));
        checkOutput({tag, " err_stray"}, 32'(err_stray), 32'(eErr));
    endtask

    initial begin
        logic        wbV, ldV, rsvV;
        logic [3:0]  wbRdR, ldRdR, rsvRdR, c1R, c2R;
        logic [31:0] wbDR, ldDR;
        logic        eWbR, eLdR, eRsvR, ldTurn, wbWants, gLd, gWb;
        logic [15:0] oldBusy;
        logic [3:0]  expRd;

        totalChecks = 0;
        badChecks   = 0;
        res = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed table: inputs for the cycle, expected combinational
        // outputs and the registered state visible in that cycle.
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setExp(0, 1, 1, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
        setIn(1, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        setExp(1, 1, 1, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
        setIn(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setExp(2, 1, 1, 1, 0, 0, 1, 5, 32'h1234, 16'h0000, 0);
        setIn(3, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        setExp(3, 1, 1, 1, 0, 0, 0, 5, 32'h1234, 16'h0000, 0);
        setIn(4, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        setExp(4, 1, 1, 0, 1, 0, 0, 5, 32'h1234, 16'h0008, 0);
        setIn(5, 0, 0, 0, 1, 3, 32'hAAAA0003, 0, 0, 3, 0);
        setExp(5, 0, 1, 1, 1, 0, 0, 5, 32'h1234, 16'h0008, 0);
        setIn(6, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0);
        setExp(6, 1, 1, 0, 1, 0, 1, 3, 32'hAAAA0003, 16'h0008, 0);
        setIn(7, 0, 0, 0, 0, 0, 0, 0, 3, 3, 3);
        setExp(7, 1, 1, 1, 0, 0, 0, 3, 32'hAAAA0003, 16'h0000, 0);
        setIn(8, 0, 0, 0, 0, 0, 0, 1, 7, 0, 7);
        setExp(8, 1, 1, 1, 0, 0, 0, 3, 32'hAAAA0003, 16'h0000, 0);
        setIn(9, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 7);
        setExp(9, 0, 1, 1, 0, 1, 0, 3, 32'hAAAA0003, 16'h0080, 0);
        setIn(10, 1, 7, 32'h77, 1, 7, 32'h1007, 0, 0, 0, 7);
        setExp(10, 0, 1, 1, 0, 1, 0, 3, 32'hAAAA0003, 16'h0080, 0);
        setIn(11, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 7);
        setExp(11, 0, 1, 1, 0, 1, 1, 7, 32'h1007, 16'h0080, 0);
        setIn(12, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 7);
        setExp(12, 1, 1, 1, 0, 0, 0, 7, 32'h1007, 16'h0000, 0);
        setIn(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setExp(13, 1, 1, 1, 0, 0, 1, 7, 32'h77, 16'h0000, 0);
        setIn(14, 0, 0, 0, 1, 9, 32'h9999, 0, 0, 0, 0);
        setExp(14, 0, 1, 1, 0, 0, 0, 7, 32'h77, 16'h0000, 0);
        setIn(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setExp(15, 1, 1, 1, 0, 0, 1, 9, 32'h9999, 16'h0000, 1);
        setIn(16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setExp(16, 1, 1, 1, 0, 0, 0, 9, 32'h9999, 16'h0000, 1);

        repeat (2) @(negedge clk);
        res = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].wbV, vecs[i].wbRd, vecs[i].wbD, vecs[i].ldV, vecs[i].ldRd,
                          vecs[i].ldD, vecs[i].rsvV, vecs[i].rsvRd, vecs[i].c1, vecs[i].c2);
            #1;
            checkAll($sformatf("vec%0d", i), vecs[i].eWbR, vecs[i].eLdR, vecs[i].eRsvR,
                     vecs[i].eH1, vecs[i].eH2, vecs[i].eEn, vecs[i].eRd, vecs[i].eData,
                     vecs[i].eBusy, vecs[i].eErr);
        end

        // Contention: wb and ld both valid and eligible for four cycles.
        expRd = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                applyStimulus(1, 4'(10 + i), 32'(32'hB000 + i), 1, 1, 32'(32'hC000 + i), 0, 0, 0, 0);
            end else begin
                applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            #1;
            if (i > 0) begin
                checkOutput($sformatf("contend%0d rf_rd", i - 1), 32'(rf_rd), 32'(expRd));
            end
            if (i < 4) begin
`ifdef RFARB_ROUND_ROBIN_EN
                checkOutput($sformatf("contend%0d ld_ready", i), 32'(ld_ready), 32'((i % 2) == 0));
                checkOutput($sformatf("contend%0d wb_ready", i), 32'(wb_ready), 32'((i % 2) == 1));
                expRd = ((i % 2) == 0) ? 4'd1 : 4'(10 + i);
`else
                checkOutput($sformatf("contend%0d ld_ready", i), 32'(ld_ready), 32'd1);
                checkOutput($sformatf("contend%0d wb_ready", i), 32'(wb_ready), 32'd0);
                expRd = 4'd1;
`endif
            end
        end

        // Asynchronous reset while a write sits in the output stage.
        @(negedge clk);
        applyStimulus(1, 2, 32'h55, 0, 0, 0, 1, 4, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 4, 0);
        #1;
        checkOutput("prereset rf_wrtEn", 32'(rf_wrtEn), 32'd1);
        checkOutput("prereset busy", 32'(busy), 32'h0010);
        res = 1'b0;
        #1;
        checkOutput("async rf_wrtEn", 32'(rf_wrtEn), 32'd0);
        checkOutput("async busy", 32'(busy), 32'd0);
        checkOutput("async err_stray", 32'(err_stray), 32'd0);
        checkOutput("async rf_rd", 32'(rf_rd), 32'd0);
        checkOutput("async rf_wrtData", rf_wrtData, 32'd0);
        checkOutput("async hazard1", 32'(hazard1), 32'd0);
        checkOutput("async rsv_ready", 32'(rsv_ready), 32'd1);
        @(negedge clk);
        res = 1'b1;

        // Random traffic against the scoreboard model.
        mBusy = '0; mEn = 0; mRd = '0; mData = '0; mFromLd = 0; mErr = 0; mPrefLd = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            wbV    = ($urandom % 2) == 0;
            wbRdR  = 4'($urandom % 16);
            wbDR   = $urandom;
            ldV    = ($urandom % 3) != 0;
            ldRdR  = 4'($urandom % 16);
            for (int t = 0; t < 8; t++) begin
                if (!mBusy[ldRdR]) ldRdR = 4'($urandom % 16);
            end
            ldDR   = $urandom;
            rsvV   = ($urandom % 2) == 0;
            rsvRdR = 4'($urandom % 16);
            c1R    = 4'($urandom % 16);
            c2R    = 4'($urandom % 16);
            applyStimulus(wbV, wbRdR, wbDR, ldV, ldRdR, ldDR, rsvV, rsvRdR, c1R, c2R);
            #1;

            // Who may write: a wb to a register awaiting a load must wait;
            // when both contend, ld wins unless it is wb's turn.
            wbWants = wbV && !mBusy[wbRdR];
`ifdef RFARB_ROUND_ROBIN_EN
            ldTurn = mPrefLd;
`else
            ldTurn = 1'b1;
`endif
            eLdR  = !wbWants || ldTurn;
            eWbR  = !mBusy[wbRdR] && !(ldV && ldTurn);
            eRsvR = !mBusy[rsvRdR];
            checkAll($sformatf("rand%0d", cyc), eWbR, eLdR, eRsvR, mBusy[c1R], mBusy[c2R],
                     mEn, mRd, mData, mBusy, mErr);

            gLd = ldV && eLdR;
            gWb = wbV && eWbR;
            oldBusy = mBusy;
            if (mEn && mFromLd) mBusy[mRd] = 1'b0;
            if (rsvV && !oldBusy[rsvRdR]) mBusy[rsvRdR] = 1'b1;
            if (gLd && !oldBusy[ldRdR]) mErr = 1'b1;
            if (ldV && wbWants) mPrefLd = !mPrefLd;
            mEn = gLd || gWb;
            if (gLd) begin
                mRd = ldRdR; mData = ldDR; mFromLd = 1'b1;
            end else if (gWb) begin
                mRd = wbRdR; mData = wbDR; mFromLd = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
